// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a sign-fix stage.
module mdu #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(ITER + 1);

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc, acc_nx;
    logic [XLEN-1:0]     opnd, dvd_raw;
    logic                is_div, neg_q, neg_r, dz;

    logic                accept, mt_wr, sgn, a_neg, b_neg, last;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [XLEN-1:0]     diff;
    logic                ge;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, res_hi, res_lo;

    // flush in IDLE also swallows a same-cycle start, including MTHI/MTLO
    assign accept = (state == IDLE) && start && !op[2] && !flush;
    assign mt_wr  = (state == IDLE) && start && (op[2:1] == 2'b10) && !flush;
    assign sgn    = !op[0];
    assign a_neg  = sgn && in1[XLEN-1];
    assign b_neg  = sgn && in2[XLEN-1];
    assign a_mag  = a_neg ? -in1 : in1;
    assign b_mag  = b_neg ? -in2 : in2;
    assign last   = (cnt == CW'(ITER - 1));

    // One iteration: multiply adds opnd into the upper half then shifts right;
    // divide shifts left into a 33-bit partial remainder and trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        ge      = (rem_sh >= {1'b0, opnd});
        diff    = rem_sh[XLEN-1:0] - opnd;
        if (is_div)
            acc_nx = ge ? {diff, acc[XLEN-2:0], 1'b1}
                        : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nx = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!is_div) begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end else if (dz) begin
            res_hi = dvd_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (flush) state_nx = IDLE;
                     else if (last) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            dvd_raw <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // multiply: acc low = multiplier, opnd = multiplicand
                        // divide:   acc low = dividend,   opnd = divisor
                        acc     <= {{XLEN{1'b0}}, op[1] ? a_mag : b_mag};
                        opnd    <= op[1] ? b_mag : a_mag;
                        is_div  <= op[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= op[1] && a_neg;
                        dz      <= op[1] && (in2 == '0);
                        dvd_raw <= in1;
                        cnt     <= '0;
                    end else if (mt_wr) begin
                        if (op[0]) lo <= in1;
                        else       hi <= in1;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= acc_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: vector table plus multi-cycle corner sequences.
module tb_mdu;
    logic        clk, rst, start, flush, busy, done;
    logic [2:0]  op;
    logic [31:0] in1, in2, hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
    } vec_t;

    vec_t vt[10];

    mdu #(.XLEN(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called right after a negedge; returns just after the negedge following E0.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done; also watches hi/lo for premature change.
    task automatic wait_done(output int lat, output logic stable);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo; lat = -1; stable = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (hi !== h0 || lo !== l0) stable = 1'b0;
        end
    endtask

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int   lat;
        logic stable;
        launch(o, a, b);
        chk({nm, " busy"}, {31'b0, busy}, 32'd1);
        wait_done(lat, stable);
        chk({nm, " latency"}, lat, 32'd33);
        chk({nm, " stable"}, {31'b0, stable}, 32'd1);
        chk({nm, " hi"}, hi, ehi);
        chk({nm, " lo"}, lo, elo);
        @(negedge clk);
        chk({nm, " done1"}, {31'b0, done}, 32'd0);
        chk({nm, " busy0"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          lat, nd;
        logic        stable;
        logic [31:0] h0, l0;

        vt[0] = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[2] = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3] = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
        vt[4] = '{3'b011, 32'd42,       32'd0,        32'd42,       32'hFFFFFFFF};
        vt[5] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[6] = '{3'b000, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vt[7] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vt[8] = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vt[9] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(3'b100, 32'h12345678, 32'd0);
        chk("mthi hi", hi, 32'h12345678);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        chk("mthi done", {31'b0, done}, 32'd0);
        launch(3'b101, 32'h9ABCDEF0, 32'd0);
        chk("mtlo lo", lo, 32'h9ABCDEF0);
        chk("mtlo hi", hi, 32'h12345678);

        launch(3'b110, 32'h11111111, 32'd3);
        chk("nop busy", {31'b0, busy}, 32'd0);
        chk("nop hi", hi, 32'h12345678);
        chk("nop lo", lo, 32'h9ABCDEF0);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo);

        // start re-pulsed at cycle 10 while busy must be ignored
        launch(3'b000, 32'hFFFFFFFD, 32'd5);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'b011; in1 = 32'd100; in2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, stable);
        chk("restart latency", lat, 32'd23);
        chk("restart hi", hi, 32'hFFFFFFFF);
        chk("restart lo", lo, 32'hFFFFFFF1);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("restart extra done", nd, 32'd0);
        chk("restart busy", {31'b0, busy}, 32'd0);

        // start accepted in the done cycle
        launch(3'b001, 32'd3, 32'd4);
        wait_done(lat, stable);
        chk("b2b first lo", lo, 32'd12);
        launch(3'b001, 32'd5, 32'd6);
        chk("b2b busy", {31'b0, busy}, 32'd1);
        wait_done(lat, stable);
        chk("b2b latency", lat, 32'd33);
        chk("b2b lo", lo, 32'd30);
        chk("b2b hi", hi, 32'd0);
        @(negedge clk);

        // flush at cycle 15 of a DIV
        h0 = hi; l0 = lo;
        launch(3'b010, 32'hFFFFFFF9, 32'd2);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("flush done", nd, 32'd0);
        chk("flush hi", hi, h0);
        chk("flush lo", lo, l0);

        // flush in IDLE wins over a same-cycle start
        flush = 1'b1;
        launch(3'b100, 32'hDEADBEEF, 32'd0);
        flush = 1'b0;
        chk("idle flush mthi", hi, h0);
        flush = 1'b1;
        launch(3'b000, 32'd3, 32'd3);
        flush = 1'b0;
        chk("idle flush busy", {31'b0, busy}, 32'd0);

        // reset mid-MULT
        launch(3'b000, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
